// File: rtl/dual_port_block_ram_be.sv
// ---------------------------------------------------------------------------
// dual_port_block_ram_be
//
// True dual-port block RAM with per-byte write enables. After every reset a
// clear sequencer sweeps the whole array to CLEAR_VAL, one word per cycle,
// while busy is high. Port requests are ignored during the sweep.
//
// Parameters
//   WIDTH      data width in bits (multiple of BYTE_W)
//   DEPTH      number of words
//   LOG2_DEPTH address width
//   BYTE_W     bits per byte-enable lane
//   RDW_MODE   same-port read-during-write: 0 = old data, 1 = new data
//   OUT_REG    1 adds one output register stage per port
//   CLEAR_VAL  value written to every word by the clear sweep
//
// Ports
//   clk                 sole clock, rising edge
//   rst_n               synchronous active-low reset
//   busy                high while the clear sweep runs
//   en_x / wr_x         access strobe / write qualifier (x = a, b)
//   be_x                byte-lane write enables
//   addr_x / d_x        address / write data
//   q_x / valid_x       read data / pulse marking q_x updated by an access
//   collision           registered pulse: both ports wrote an overlapping
//                       lane of the same address
// ---------------------------------------------------------------------------
module dual_port_block_ram_be #(
   parameter int               WIDTH      = 64,
   parameter int               DEPTH      = 512,
   parameter int               LOG2_DEPTH = $clog2(DEPTH),
   parameter int               BYTE_W     = 8,
   parameter int               RDW_MODE   = 0,
   parameter int               OUT_REG    = 0,
   parameter logic [WIDTH-1:0] CLEAR_VAL  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    busy,

   input  logic                    en_a,
   input  logic                    wr_a,
   input  logic [WIDTH/BYTE_W-1:0] be_a,
   input  logic [LOG2_DEPTH-1:0]   addr_a,
   input  logic [WIDTH-1:0]        d_a,
   output logic [WIDTH-1:0]        q_a,
   output logic                    valid_a,

   input  logic                    en_b,
   input  logic                    wr_b,
   input  logic [WIDTH/BYTE_W-1:0] be_b,
   input  logic [LOG2_DEPTH-1:0]   addr_b,
   input  logic [WIDTH-1:0]        d_b,
   output logic [WIDTH-1:0]        q_b,
   output logic                    valid_b,

   output logic                    collision
);

   localparam int NBE = WIDTH / BYTE_W;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [LOG2_DEPTH-1:0]   clr_cnt;

   logic [WIDTH-1:0]        mem [DEPTH];

   logic                    acc_a;
   logic                    acc_b;
   logic                    wen_a;
   logic                    wen_b;
   logic                    same_addr;
   logic [NBE-1:0]          wmask_a;
   logic [NBE-1:0]          wmask_b;

   logic [WIDTH-1:0]        old_a;
   logic [WIDTH-1:0]        old_b;
   logic [WIDTH-1:0]        rdata_a;
   logic [WIDTH-1:0]        rdata_b;

   logic [WIDTH-1:0]        q1_a;
   logic [WIDTH-1:0]        q1_b;
   logic                    v1_a;
   logic                    v1_b;

   // Builds the word a port would see after its own write: written lanes
   // take the new data, the rest keep the current array contents.
   function automatic logic [WIDTH-1:0] merge_lanes(
      input logic [WIDTH-1:0] old_word,
      input logic [WIDTH-1:0] new_word,
      input logic [NBE-1:0]   lanes
   );
      logic [WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < NBE; i++) begin
         if (lanes[i]) begin
            res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
         end
      end
      return res;
   endfunction

   // Next-state decode. The sweep ends after the last word is written;
   // busy is simply "not yet in RUN", so it is already high in the cycle
   // following a reset edge.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         CLEAR: begin
            busy = 1'b1;
            if (clr_cnt == LOG2_DEPTH'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = CLEAR;
            busy    = 1'b1;
         end
      endcase
   end

   // State register and clear-address counter. The counter only advances
   // during the sweep, so it restarts from zero on every reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + LOG2_DEPTH'(1);
         end
      end
   end

   // Access qualification. Port B's write lanes are masked wherever port A
   // writes the same lane of the same address, so A wins lane-by-lane and
   // the two ports never store into the same bits on one edge.
   always_comb begin
      acc_a     = rst_n && (state_q == RUN) && en_a;
      acc_b     = rst_n && (state_q == RUN) && en_b;
      wen_a     = acc_a && wr_a;
      wen_b     = acc_b && wr_b;
      same_addr = (addr_a == addr_b);
      wmask_a   = wen_a ? be_a : '0;
      wmask_b   = wen_b ? be_b : '0;
      if (same_addr) begin
         wmask_b = wmask_b & ~wmask_a;
      end
   end

   // Read data selection. The array is read before this edge's writes take
   // effect, so a cross-port reader always sees old data. Only a port's own
   // write can be folded in, and only in write-first mode.
   always_comb begin
      old_a   = mem[addr_a];
      old_b   = mem[addr_b];
      rdata_a = old_a;
      rdata_b = old_b;
      if (RDW_MODE != 0) begin
         if (wr_a) begin
            rdata_a = merge_lanes(old_a, d_a, be_a);
         end
         if (wr_b) begin
            rdata_b = merge_lanes(old_b, d_b, be_b);
         end
      end
   end

   // Array storage. The clear sweep and port writes are mutually exclusive
   // by state, and the array itself is never reset except by the sweep.
   always_ff @(posedge clk) begin
      if (rst_n && (state_q == CLEAR)) begin
         mem[clr_cnt] <= CLEAR_VAL;
      end
      for (int i = 0; i < NBE; i++) begin
         if (wmask_a[i]) begin
            mem[addr_a][i*BYTE_W +: BYTE_W] <= d_a[i*BYTE_W +: BYTE_W];
         end
         if (wmask_b[i]) begin
            mem[addr_b][i*BYTE_W +: BYTE_W] <= d_b[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // First output stage. q holds between accesses; valid pulses once per
   // accepted access. Reset discards whatever was being read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q1_a <= '0;
         q1_b <= '0;
         v1_a <= 1'b0;
         v1_b <= 1'b0;
      end else begin
         v1_a <= acc_a;
         v1_b <= acc_b;
         if (acc_a) begin
            q1_a <= rdata_a;
         end
         if (acc_b) begin
            q1_b <= rdata_b;
         end
      end
   end

   // Collision flag: both ports wrote the same address with at least one
   // lane in common. Registered, so it shows up the cycle after the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         collision <= 1'b0;
      end else begin
         collision <= wen_a && wen_b && same_addr && ((be_a & be_b) != '0);
      end
   end

   // Optional second output stage. It only reloads when the first stage
   // carries a fresh result, so q keeps holding between accesses.
   if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] q2_a;
      logic [WIDTH-1:0] q2_b;
      logic             v2_a;
      logic             v2_b;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            q2_a <= '0;
            q2_b <= '0;
            v2_a <= 1'b0;
            v2_b <= 1'b0;
         end else begin
            v2_a <= v1_a;
            v2_b <= v1_b;
            if (v1_a) begin
               q2_a <= q1_a;
            end
            if (v1_b) begin
               q2_b <= q1_b;
            end
         end
      end

      assign q_a     = q2_a;
      assign q_b     = q2_b;
      assign valid_a = v2_a;
      assign valid_b = v2_b;
   end else begin : g_no_out_reg
      assign q_a     = q1_a;
      assign q_b     = q1_b;
      assign valid_a = v1_a;
      assign valid_b = v1_b;
   end

endmodule
